// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to the 16-bit word memory.
// Request and response use valid/ready handshakes; faults skip memory.
module load_store_unit #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [15:0]       cpu_req_wdata,
    output logic              cpu_rsp_valid,
    input  logic              cpu_rsp_ready,
    output logic [15:0]       cpu_rsp_rdata,
    output logic              cpu_rsp_err,
    output logic [15:0]       mem_dataaddr,
    output logic [15:0]       mem_datawrite,
    input  logic [15:0]       mem_dataread
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [31:0] LIMIT = MEM_SIZE;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        fault;

    assign fault = ({{(32-ADDR_W){1'b0}}, cpu_req_addr} >= LIMIT);

    // Next-state and registered-output decode for the three-state access FSM
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    if (fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        rdata_d     = 16'h0;
                        addr_d      = 16'h0;
                    end else begin
                        state_d = ACCESS;
                        addr_d  = {~cpu_req_we, cpu_req_we, cpu_req_addr};
                        wdata_d = cpu_req_we ? cpu_req_wdata : 16'h0;
                    end
                end
            end
            ACCESS: begin
                rdata_d     = addr_q[15] ? mem_dataread : 16'h0;
                err_d       = 1'b0;
                addr_d      = 16'h0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (cpu_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the memory flags at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 16'h0;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign cpu_req_ready = (state_q == IDLE);
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_rdata = rdata_q;
    assign cpu_rsp_err   = err_q;
    assign mem_dataaddr  = addr_q;
    assign mem_datawrite = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus stall, reset and
// back-to-back sequences against a small behavioural memory.
module tb_load_store_unit;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cpu_req_valid = 0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 0;
    logic [13:0] cpu_req_addr = 0;
    logic [15:0] cpu_req_wdata = 0;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready = 1;
    logic [15:0] cpu_rsp_rdata;
    logic        cpu_rsp_err;
    logic [15:0] mem_dataaddr;
    logic [15:0] mem_datawrite;
    logic [15:0] mem_dataread;

    int n_checks = 0;
    int n_err = 0;

    logic [15:0] mem [0:1023];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_ready (cpu_rsp_ready),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .cpu_rsp_err   (cpu_rsp_err),
        .mem_dataaddr  (mem_dataaddr),
        .mem_datawrite (mem_datawrite),
        .mem_dataread  (mem_dataread)
    );

    always @(posedge clk)
        if (mem_dataaddr[14] && mem_dataaddr[13:10] == 4'h0)
            mem[mem_dataaddr[9:0]] <= mem_datawrite;

    assign mem_dataread = mem_dataaddr[15] ? mem[mem_dataaddr[9:0]] : 16'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (mem_dataaddr[15] && mem_dataaddr[14]) begin
                n_err++;
                $display("FAIL flags_both: dataaddr=%h want rd/wr exclusive",
                         mem_dataaddr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [13:0] a,
                          input logic [15:0] wd,
                          output logic [15:0] rd, output logic er,
                          output int lat, output int fcyc,
                          output logic [15:0] faddr,
                          output logic [15:0] fdata);
        int k;
        @(negedge clk);
        cpu_req_valid = 1;
        cpu_req_we    = we;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
        cpu_rsp_ready = 1;
        k = 0;
        while (!cpu_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cpu_req_valid = 0;
        lat = 0; fcyc = 0; faddr = 0; fdata = 0; rd = 16'hxxxx; er = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            if (mem_dataaddr[15] || mem_dataaddr[14]) begin
                fcyc++;
                faddr = mem_dataaddr;
                fdata = mem_datawrite;
            end
            if (cpu_rsp_valid) begin
                lat = c;
                rd  = cpu_rsp_rdata;
                er  = cpu_rsp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          fcyc;
        logic [15:0] faddr;
        logic [15:0] fdata;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [15:0] rd, fa, fd;
        logic        er;
        int          lat, fc;
        int          idx, got, last;

        vt[0] = '{1'b1, 14'h005, 16'hBEEF, 16'h0000, 1'b0, 2, 1, 16'h4005, 16'hBEEF};
        vt[1] = '{1'b0, 14'h005, 16'h0000, 16'hBEEF, 1'b0, 2, 1, 16'h8005, 16'h0000};
        vt[2] = '{1'b1, 14'h3FF, 16'h1234, 16'h0000, 1'b0, 2, 1, 16'h43FF, 16'h1234};
        vt[3] = '{1'b0, 14'h3FF, 16'h0000, 16'h1234, 1'b0, 2, 1, 16'h83FF, 16'h0000};
        vt[4] = '{1'b1, 14'h000, 16'h0F0F, 16'h0000, 1'b0, 2, 1, 16'h4000, 16'h0F0F};
        vt[5] = '{1'b1, 14'h400, 16'hFFFF, 16'h0000, 1'b1, 1, 0, 16'h0000, 16'h0000};
        vt[6] = '{1'b0, 14'h000, 16'h0000, 16'h0F0F, 1'b0, 2, 1, 16'h8000, 16'h0000};
        vt[7] = '{1'b0, 14'h3FFF, 16'h0000, 16'h0000, 1'b1, 1, 0, 16'h0000, 16'h0000};
        vt[8] = '{1'b1, 14'h2A5, 16'hA5A5, 16'h0000, 1'b0, 2, 1, 16'h42A5, 16'hA5A5};
        vt[9] = '{1'b0, 14'h2A5, 16'h0000, 16'hA5A5, 1'b0, 2, 1, 16'h82A5, 16'h0000};

        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(cpu_req_ready), 32'h1);
        chk("rst rsp_valid", 32'(cpu_rsp_valid), 32'h0);
        chk("rst rdata", 32'(cpu_rsp_rdata), 32'h0);
        chk("rst err", 32'(cpu_rsp_err), 32'h0);
        chk("rst dataaddr", 32'(mem_dataaddr), 32'h0);
        chk("rst datawrite", 32'(mem_datawrite), 32'h0);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            do_req(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat, fc, fa, fd);
            chk($sformatf("v%0d rdata", i), 32'(rd), 32'(vt[i].rdata));
            chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].err));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d flag_cycles", i), 32'(fc), 32'(vt[i].fcyc));
            chk($sformatf("v%0d flag_addr", i), 32'(fa), 32'(vt[i].faddr));
            chk($sformatf("v%0d flag_wdata", i), 32'(fd), 32'(vt[i].fdata));
        end

        // Response stall on a load of 0x005
        @(negedge clk);
        cpu_rsp_ready = 0;
        cpu_req_valid = 1;
        cpu_req_we    = 0;
        cpu_req_addr  = 14'h005;
        @(negedge clk);
        cpu_req_valid = 0;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall%0d rsp_valid", s), 32'(cpu_rsp_valid), 32'h1);
            chk($sformatf("stall%0d rdata", s), 32'(cpu_rsp_rdata), 32'hBEEF);
            chk($sformatf("stall%0d req_ready", s), 32'(cpu_req_ready), 32'h0);
            chk($sformatf("stall%0d dataaddr", s), 32'(mem_dataaddr), 32'h0);
            @(negedge clk);
        end
        cpu_rsp_ready = 1;
        cpu_req_valid = 1;
        cpu_req_we    = 0;
        cpu_req_addr  = 14'h3FF;
        @(negedge clk);
        chk("resume idle req_ready", 32'(cpu_req_ready), 32'h1);
        chk("resume idle rsp_valid", 32'(cpu_rsp_valid), 32'h0);
        chk("resume not_early", 32'(mem_dataaddr), 32'h0);
        @(negedge clk);
        chk("resume accept", 32'(mem_dataaddr), 32'h83FF);
        cpu_req_valid = 0;
        @(negedge clk);
        chk("resume rsp_valid", 32'(cpu_rsp_valid), 32'h1);
        chk("resume rdata", 32'(cpu_rsp_rdata), 32'h1234);
        @(negedge clk);

        // Reset in the middle of a store to 0x010
        do_req(1'b1, 14'h010, 16'h5555, rd, er, lat, fc, fa, fd);
        chk("preload err", 32'(er), 32'h0);
        @(negedge clk);
        cpu_req_valid = 1;
        cpu_req_we    = 1;
        cpu_req_addr  = 14'h010;
        cpu_req_wdata = 16'hDEAD;
        @(posedge clk);
        #1;
        chk("mid store dataaddr", 32'(mem_dataaddr), 32'h4010);
        cpu_req_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("async dataaddr", 32'(mem_dataaddr), 32'h0);
        chk("async datawrite", 32'(mem_datawrite), 32'h0);
        chk("async rsp_valid", 32'(cpu_rsp_valid), 32'h0);
        chk("async rdata", 32'(cpu_rsp_rdata), 32'h0);
        chk("async err", 32'(cpu_rsp_err), 32'h0);
        chk("async req_ready", 32'(cpu_req_ready), 32'h1);
        @(negedge clk);
        chk("mem 0x010 kept", 32'(mem[10'h010]), 32'h5555);
        rst_n = 1;
        do_req(1'b0, 14'h010, 16'h0000, rd, er, lat, fc, fa, fd);
        chk("post rst load", 32'(rd), 32'h5555);
        chk("post rst lat", 32'(lat), 32'h2);

        // Ten back-to-back requests, responses every third cycle
        idx = 0;
        got = 0;
        last = 0;
        cpu_rsp_ready = 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            if (cpu_rsp_valid) begin
                chk($sformatf("b2b%0d rdata", got), 32'(cpu_rsp_rdata),
                    got < 5 ? 32'h0 : 32'hA000 + 32'(got - 5));
                chk($sformatf("b2b%0d err", got), 32'(cpu_rsp_err), 32'h0);
                if (got > 0)
                    chk($sformatf("b2b%0d spacing", got), 32'(cyc - last), 32'h3);
                last = cyc;
                got++;
            end
            if (cpu_req_ready) begin
                if (idx < 10) begin
                    cpu_req_valid = 1;
                    cpu_req_we    = (idx < 5);
                    cpu_req_addr  = 14'h100 + 14'(idx % 5);
                    cpu_req_wdata = 16'hA000 + 16'(idx % 5);
                    idx++;
                end else begin
                    cpu_req_valid = 0;
                end
            end
            @(negedge clk);
        end
        cpu_req_valid = 0;
        chk("b2b count", 32'(got), 32'd10);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
